act_argmax: RTL

- Output stage directly downstream of the neuron accumulator (`acc`).
- Consumes one 22-bit signed accumulator result per neuron of the output layer.
- Applies ReLU and requantises each result to 8 bits for the next layer or debug readout.
- Tracks the running maximum over a frame of NUM_CLASSES results and reports the winning class index at frame end.

---
 rtl/act_argmax_if.sv | 47 ++++
 rtl/act_argmax.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/act_argmax_if.sv
// act_argmax_if
// Bundles the stream and result signals of the act_argmax output stage.
//   frame_clr    upstream -> stage  synchronous abort of the partial frame
//   in_valid     upstream -> stage  in_data is valid this cycle
//   in_data      upstream -> stage  signed 22-bit accumulator result
//   in_ready     stage -> upstream  stage can accept in_data this cycle
//   act_valid    stage -> upstream  act_out valid (one pulse per transfer)
//   act_out      stage -> upstream  ReLU + requantised 8-bit activation
//   class_valid  stage -> upstream  one-cycle pulse, class_idx is final
//   class_idx    stage -> upstream  winning class of the last frame
//   busy         stage -> upstream  a frame is partially collected
//   max_score    stage -> upstream  winning raw score (only with ACT_ARGMAX_SCORE_OUT_EN)
// The master modport is the upstream side; the stage itself uses slave.
interface act_argmax_if #(
    parameter int IDX_W = 4
);
    logic                    frame_clr;
    logic                    in_valid;
    logic signed [21:0]      in_data;
    logic                    in_ready;
    logic                    act_valid;
    logic [7:0]              act_out;
    logic                    class_valid;
    logic [IDX_W-1:0]        class_idx;
    logic                    busy;
`ifdef ACT_ARGMAX_SCORE_OUT_EN
    logic signed [21:0]      max_score;

    modport master (
        output frame_clr, in_valid, in_data,
        input  in_ready, act_valid, act_out, class_valid, class_idx, busy, max_score
    );
    modport slave (
        input  frame_clr, in_valid, in_data,
        output in_ready, act_valid, act_out, class_valid, class_idx, busy, max_score
    );
`else
    modport master (
        output frame_clr, in_valid, in_data,
        input  in_ready, act_valid, act_out, class_valid, class_idx, busy
    );
    modport slave (
        input  frame_clr, in_valid, in_data,
        output in_ready, act_valid, act_out, class_valid, class_idx, busy
    );
`endif
endinterface

// File: rtl/act_argmax.sv
// act_argmax
// Output stage behind the neuron accumulator. Every accepted result is
// passed through ReLU and requantised to 8 bits (one cycle latency), and the
// raw signed results of a frame of NUM_CLASSES values are reduced to the index
// of the largest one, reported with a one-cycle class_valid pulse.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active low
//   bus   act_argmax_if slave side (stream in, activation and class out)
// Optional build macro: ACT_ARGMAX_SCORE_OUT_EN adds bus.max_score, the
// signed maximum of the last frame, updated together with class_idx.
module act_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int SHIFT       = 8,
    parameter int IDX_W       = 4
) (
    input  logic clk,
    input  logic rst,
    act_argmax_if.slave bus
);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   class_idx_q, class_idx_d;
    logic signed [21:0] max_q, max_d;
    logic               act_valid_q, act_valid_d;
    logic [7:0]         act_out_q, act_out_d;
`ifdef ACT_ARGMAX_SCORE_OUT_EN
    logic signed [21:0] max_score_q, max_score_d;
`endif

    logic               in_ready;
    logic               transfer;
    logic               new_max;
    logic signed [21:0] shifted;

    always_comb begin
        in_ready  = (state_q != DONE);
        // An abort in the same cycle drops the data completely.
        transfer  = bus.in_valid && in_ready && !bus.frame_clr;
        // The first value of a frame always seeds the maximum; later values
        // must be strictly larger so that ties keep the lowest index.
        new_max   = (count_q == '0) || ($signed(bus.in_data) > max_q);
        shifted   = $signed(bus.in_data) >>> SHIFT;

        act_valid_d = transfer;
        act_out_d   = act_out_q;
        if (transfer) begin
            if (bus.in_data[21]) begin
                act_out_d = 8'd0;
            end else if (shifted > 22'sd255) begin
                act_out_d = 8'd255;
            end else begin
                act_out_d = shifted[7:0];
            end
        end
    end

    // Frame sequencing and argmax. The winner of the frame is resolved on the
    // last transfer so that class_idx is already final during DONE.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        max_d       = max_q;
        idx_d       = idx_q;
        class_idx_d = class_idx_q;
`ifdef ACT_ARGMAX_SCORE_OUT_EN
        max_score_d = max_score_q;
`endif
        case (state_q)
            IDLE, COLLECT: begin
                if (transfer) begin
                    if (new_max) begin
                        max_d = bus.in_data;
                        idx_d = count_q;
                    end
                    if (count_q == LAST_IDX) begin
                        state_d     = DONE;
                        count_d     = '0;
                        class_idx_d = new_max ? count_q : idx_q;
`ifdef ACT_ARGMAX_SCORE_OUT_EN
                        max_score_d = new_max ? bus.in_data : max_q;
`endif
                    end else begin
                        state_d = COLLECT;
                        count_d = count_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (bus.frame_clr) begin
            state_d = IDLE;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            class_idx_q <= '0;
            act_valid_q <= 1'b0;
            act_out_q   <= 8'd0;
`ifdef ACT_ARGMAX_SCORE_OUT_EN
            max_score_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            max_q       <= max_d;
            idx_q       <= idx_d;
            class_idx_q <= class_idx_d;
            act_valid_q <= act_valid_d;
            act_out_q   <= act_out_d;
`ifdef ACT_ARGMAX_SCORE_OUT_EN
            max_score_q <= max_score_d;
`endif
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.busy        = (state_q == COLLECT);
    assign bus.class_valid = (state_q == DONE);
    assign bus.class_idx   = class_idx_q;
    assign bus.act_valid   = act_valid_q;
    assign bus.act_out     = act_out_q;
`ifdef ACT_ARGMAX_SCORE_OUT_EN
    assign bus.max_score   = max_score_q;
`endif

endmodule
